// File: rtl/decim_pkg.sv
// Shared types and default parameters for the stream decimator and its output stage.
package decim_pkg;

    typedef enum logic {
        DECIM_DROP = 1'b0,
        DECIM_AVG  = 1'b1
    } decim_mode_t;

    localparam int DECIM_IN_W      = 16;
    localparam int DECIM_OUT_W     = 32;
    localparam int DECIM_OUT_SHIFT = 8;
    localparam int DECIM_MAX_LOG2  = 6;
    localparam int DECIM_CNT_W     = 16;

endpackage

// File: rtl/decim_out_reg.sv
// Single-entry valid/ready holding register; accepts a new word whenever empty or draining.
module decim_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/stream_decimator.sv
// Power-of-two sample-rate decimator (keep-last or group average) feeding a held,
// widened output word; counts input samples lost while the output is stalled.
module stream_decimator
    import decim_pkg::*;
#(
    parameter int IN_W      = DECIM_IN_W,
    parameter int OUT_W     = DECIM_OUT_W,
    parameter int OUT_SHIFT = DECIM_OUT_SHIFT,
    parameter int MAX_LOG2  = DECIM_MAX_LOG2,
    parameter int CNT_W     = DECIM_CNT_W,
    localparam int LOG2_W   = $clog2(MAX_LOG2 + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [LOG2_W-1:0] decim_log2,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [IN_W-1:0]   x_data,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [OUT_W-1:0]  y_data,
    output logic [CNT_W-1:0]  drop_count
);

    localparam int ACC_W = IN_W + MAX_LOG2;
    localparam int IDX_W = MAX_LOG2 + 1;
    localparam int EXT_W = OUT_W - OUT_SHIFT;

    logic [MAX_LOG2-1:0]     r_idx;
    logic signed [ACC_W-1:0] r_acc;
    logic [LOG2_W-1:0]       r_log2;
    decim_mode_t             r_mode;
    logic [CNT_W-1:0]        r_drop_count;

    logic                    w_first;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_in_ready;
    logic [LOG2_W-1:0]       w_log2_in;
    logic [LOG2_W-1:0]       w_log2;
    decim_mode_t             w_mode;
    logic [IDX_W-1:0]        w_group_len;
    logic signed [ACC_W-1:0] w_x_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic [IN_W-1:0]         w_res;
    logic [EXT_W-1:0]        w_ext;
    logic [OUT_W-1:0]        w_word;

    // Group parameters come from the live inputs on the first beat, from the latch afterwards.
    assign w_first   = (r_idx == '0);
    assign w_log2_in = (decim_log2 > LOG2_W'(MAX_LOG2)) ? LOG2_W'(MAX_LOG2) : decim_log2;
    assign w_log2    = w_first ? w_log2_in : r_log2;
    assign w_mode    = w_first ? decim_mode_t'(mode) : r_mode;

    assign w_accept    = x_valid && w_in_ready;
    assign w_group_len = IDX_W'(1) << w_log2;
    assign w_last      = ({1'b0, r_idx} == (w_group_len - 1'b1));

    assign w_x_ext = {{MAX_LOG2{x_data[IN_W-1]}}, x_data};
    assign w_sum   = (w_first ? ACC_W'(0) : r_acc) + w_x_ext;
    assign w_res   = (w_mode == DECIM_AVG) ? IN_W'(w_sum >>> w_log2) : x_data;

    generate
        if (EXT_W > IN_W) begin : g_sext
            assign w_ext = {{(EXT_W - IN_W){w_res[IN_W-1]}}, w_res};
        end else begin : g_nosext
            assign w_ext = w_res;
        end
    endgenerate

    assign w_word = OUT_W'(w_ext) << OUT_SHIFT;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx        <= '0;
            r_acc        <= '0;
            r_log2       <= '0;
            r_mode       <= DECIM_DROP;
            r_drop_count <= '0;
        end else begin
            if (w_accept) begin
                r_acc <= w_sum;
                r_idx <= w_last ? '0 : r_idx + 1'b1;
                if (w_first) begin
                    r_log2 <= w_log2_in;
                    r_mode <= w_mode;
                end
            end
            if (x_valid && !w_in_ready && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    decim_out_reg #(
        .W(OUT_W)
    ) u_out_reg (
        .clk    (clk),
        .reset  (reset),
        .i_valid(w_accept && w_last),
        .o_ready(w_in_ready),
        .i_data (w_word),
        .o_valid(y_valid),
        .i_ready(y_ready),
        .o_data (y_data)
    );

    assign x_ready    = w_in_ready;
    assign drop_count = r_drop_count;

endmodule

// File: doc/stream_decimator.md
# stream_decimator

Parametrised streaming decimator between the audio codec sample stream and the FFT input. Reduces the sample rate by a runtime-selectable power of two, either by keeping one sample per group (drop mode) or by averaging each group (average mode), then widens the result into the FFT word format. Unlike the inline decimation it replaces, it holds its output under backpressure and counts the input samples it is forced to drop.

## Interface
Parameters:
- IN_W, 16, input sample width (signed two's complement)
- OUT_W, 32, output word width
- OUT_SHIFT, 8, zero LSBs appended after sign extension; OUT_W >= IN_W + OUT_SHIFT required
- MAX_LOG2, 6, largest decimation exponent (R up to 2^MAX_LOG2)
- CNT_W, 16, drop counter width

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- mode  in  1  0 = drop (keep last sample of group), 1 = average
- decim_log2  in  $clog2(MAX_LOG2+1)  R = 2^decim_log2; values > MAX_LOG2 clamp to MAX_LOG2
- x_valid  in  1  input sample valid
- x_ready  out  1  block can accept input this cycle
- x_data  in  IN_W  input sample
- y_valid  out  1  output word valid
- y_ready  in  1  downstream accepts
- y_data  out  OUT_W  output word
- drop_count  out  CNT_W  saturating count of cycles with x_valid && !x_ready

## Operation
- Accept beat: x_valid && x_ready. Output beat: y_valid && y_ready.
- Group state: idx (MAX_LOG2 bits), acc (IN_W+MAX_LOG2 signed), r_log2 (latched).
- r_log2 and mode are latched on the first accepted beat of each group (idx==0); changes mid-group have no effect until the next group.
- Each accepted beat: acc <= (idx==0 ? 0 : acc) + sext(x_data); idx increments. Last beat of group: idx == 2^r_log2 - 1; idx returns to 0.
- On last beat, result computed from the updated sum:
  - drop mode: x_data of that beat.
  - average mode: (acc + x_data) >>> r_log2 (arithmetic, truncation toward -inf), always fits IN_W.
- y_data = {sign-extended result to OUT_W-OUT_SHIFT bits, OUT_SHIFT zeros}.
- R=1 (decim_log2=0): every accepted beat produces an output; both modes identical.
- Output register: single entry. x_ready = !y_valid || y_ready. An input arrives regardless of x_ready (upstream has no handshake); refused beats are lost and counted.
- drop_count increments by 1 each cycle x_valid && !x_ready; saturates at 2^CNT_W-1; cleared only by reset.

## Timing
- Reset values: y_valid 0, y_data 0, drop_count 0, idx 0, acc 0, x_ready 1 the cycle after reset deasserts.
- Reset mid-group discards partial group and any held output; first post-reset beat starts a new group.
- Latency: last accepted beat of group at cycle n -> y_valid=1 with y_data at cycle n+1.
- y_valid/y_data held stable until output beat. Output beat and completing input beat in the same cycle: register reloads, y_valid stays 1, no bubble.
- Non-completing input beats are accepted while y_valid && !y_ready? No: x_ready is 0 whenever the output is held, for all beats (simple, testable rule).
- Full throughput: one output per R accepted inputs with y_ready tied high.

## Structure
- Package decim_pkg: typedef enum logic {DECIM_DROP, DECIM_AVG} decim_mode_t; localparam defaults for IN_W, OUT_W, OUT_SHIFT, MAX_LOG2.
- One sub-module is natural: decim_out_reg (single-entry valid/ready holding register, width parameter), reused for other stream stages.
- Accumulator/index logic stays in stream_decimator.

## Test plan
- Pass-through: decim_log2=0, mode=0, x_data=16'h8000, y_ready=1 -> y_data=32'hFF800000 one cycle later; 0x7FFF -> 32'h007FFF00.
- Drop mode R=64: ramp 0..127 continuous -> exactly two outputs, data 63 and 127 (<<8), drop_count=0.
- Average mode R=4: inputs 1,2,3,6 -> 3; inputs -1,-2,-2,-2 -> -2 (floor of -7/4), i.e. 32'hFFFFFE00.
- Backpressure: R=1, y_ready=0 for 5 cycles with x_valid=1 -> first word held unchanged, x_ready=0, drop_count=4, no further output until y_ready; then first word accepted.
- Mid-group change: mode=1, R=4, after 2 beats set decim_log2=1 -> current group still takes 4 beats; next group uses 2.
- Reset after 3 of 4 beats, then 4 beats of value 8 -> single output 8, no residue from earlier beats; drop_count saturation at CNT_W=4 after 20 refused cycles reads 15.
